// File: rtl/calc_result_encoder.sv
// Converts a 32-bit ALU result to ASCII decimal (optional '-', CR LF) and streams
// it byte by byte over a valid/ready handshake to the UART transmitter.
module calc_result_encoder #(
    parameter bit EOL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_done,
    input  logic [31:0] calc_res,
    input  logic        res_signed,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        uout_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, CONV, SIGN, DIGIT, CR, LF} state_t;

    state_t      state;
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [4:0]  cnt;
    logic [3:0]  ptr;
    logic        neg;

    logic [31:0] mag;
    logic [39:0] bcd_adj;
    logic [39:0] bcd_step;
    logic [3:0]  top_ptr;
    logic        accept;

    function automatic logic [7:0] digit_char(input logic [39:0] b, input logic [3:0] p);
        return 8'h30 + {4'h0, b[{p, 2'b00} +: 4]};
    endfunction

    assign mag    = (res_signed && calc_res[31]) ? (~calc_res + 32'd1) : calc_res;
    assign accept = uout_valid & tx_ready;

    // One double-dabble step, plus the most significant nonzero digit of its result.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = {bcd_adj[38:0], bin[31]};
        top_ptr  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_step[4*i +: 4] != 4'd0) begin
                top_ptr = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ptr        <= '0;
            neg        <= 1'b0;
            tx_data    <= 8'h00;
            uout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= alu_done && (state != IDLE);
            case (state)
                IDLE: begin
                    if (alu_done) begin
                        bin   <= mag;
                        neg   <= res_signed & calc_res[31];
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd <= bcd_step;
                    bin <= {bin[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        ptr        <= top_ptr;
                        uout_valid <= 1'b1;
                        if (neg) begin
                            state   <= SIGN;
                            tx_data <= 8'h2D;
                        end else begin
                            state   <= DIGIT;
                            tx_data <= digit_char(bcd_step, top_ptr);
                        end
                    end
                end
                SIGN: begin
                    if (accept) begin
                        state   <= DIGIT;
                        tx_data <= digit_char(bcd, ptr);
                    end
                end
                DIGIT: begin
                    if (accept) begin
                        if (ptr == 4'd0) begin
                            if (EOL_EN) begin
                                state   <= CR;
                                tx_data <= 8'h0D;
                            end else begin
                                state      <= IDLE;
                                tx_data    <= 8'h00;
                                uout_valid <= 1'b0;
                                busy       <= 1'b0;
                            end
                        end else begin
                            ptr     <= ptr - 4'd1;
                            tx_data <= digit_char(bcd, ptr - 4'd1);
                        end
                    end
                end
                CR: begin
                    if (accept) begin
                        state   <= LF;
                        tx_data <= 8'h0A;
                    end
                end
                LF: begin
                    if (accept) begin
                        state      <= IDLE;
                        tx_data    <= 8'h00;
                        uout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    uout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_result_encoder.sv
// Self-checking bench for calc_result_encoder: frames are compared against a
// decimal-formatting reference model, with random backpressure and overrun/reset cases.
module tb_calc_result_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_done = 1'b0;
    logic [31:0] calc_res = '0;
    logic        res_signed = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        uout_valid;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    calc_result_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .alu_done   (alu_done),
        .calc_res   (calc_res),
        .res_signed (res_signed),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .uout_valid (uout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected bytes from plain integer arithmetic.
    function automatic void build_expected(input logic [31:0] v, input logic sg);
        longint x;
        int sv;
        logic [7:0] digs[$];
        sv = v;
        x  = sg ? longint'(sv) : longint'(v);
        exp_q.delete();
        if (x < 0) begin
            exp_q.push_back(8'h2D);
            x = -x;
        end
        do begin
            digs.push_front(8'h30 + 8'(x % 10));
            x = x / 10;
        end while (x != 0);
        foreach (digs[i]) exp_q.push_back(digs[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Entered and left just after a falling edge.
    // mode 0: tx_ready held 1; mode 1: random tx_ready.
    task automatic run_frame(input string name, input logic [31:0] v, input logic sg,
                             input int mode, input int ovr_cycle, input int rst_bytes);
        logic [7:0] rx[$];
        int cyc = 1, first = -1, last = -1, ovr = 0;
        logic pv = 1'b0, prdy = 1'b0;
        logic [7:0] pd = 8'h00;
        bit done = 0;
        build_expected(v, sg);
        alu_done = 1'b1; calc_res = v; res_signed = sg;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check({name, "_busy_start"}, busy, 1);
        while (!done && cyc < 3000) begin
            tx_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cyc == ovr_cycle) begin
                alu_done = 1'b1; calc_res = 32'd7; res_signed = 1'b0;
            end else begin
                alu_done = 1'b0;
            end
            @(negedge clk);
            if (pv && !prdy) begin
                check({name, "_hold_valid"}, uout_valid, 1);
                check({name, "_hold_data"}, tx_data, pd);
            end
            if (overrun) ovr++;
            if (uout_valid && tx_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                rx.push_back(tx_data);
            end
            pv = uout_valid; pd = tx_data; prdy = tx_ready;
            if (rst_bytes >= 0 && rx.size() == rst_bytes) begin
                @(posedge clk); #1;
                rst = 1'b1; tx_ready = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check({name, "_rst_valid"}, uout_valid, 0);
                check({name, "_rst_busy"}, busy, 0);
                check({name, "_rst_data"}, tx_data, 0);
                done = 1;
            end else if (!busy) begin
                done = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        alu_done = 1'b0;
        check({name, "_finished"}, 32'(done), 1);
        if (rst_bytes >= 0) begin
            check({name, "_count"}, rx.size(), rst_bytes);
            for (int i = 0; i < rst_bytes && i < rx.size(); i++)
                check({name, "_byte"}, rx[i], exp_q[i]);
        end else begin
            check({name, "_count"}, rx.size(), exp_q.size());
            foreach (exp_q[i])
                if (i < rx.size()) check({name, "_byte"}, rx[i], exp_q[i]);
            check({name, "_overrun"}, ovr, (ovr_cycle > 0) ? 1 : 0);
            if (mode == 0) begin
                check({name, "_latency"}, first, 33);
                check({name, "_span"}, last - first, exp_q.size() - 1);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", tx_data, 0);
        check("reset_valid", uout_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;

        run_frame("uns_zero", 32'h0, 1'b0, 0, -1, -1);
        run_frame("uns_max", 32'hFFFF_FFFF, 1'b0, 0, -1, -1);
        run_frame("sgn_m1", 32'hFFFF_FFFF, 1'b1, 0, -1, -1);
        run_frame("sgn_min", 32'h8000_0000, 1'b1, 0, -1, -1);
        run_frame("sgn_100", 32'h64, 1'b1, 0, -1, -1);
        run_frame("backpr", 32'd12345, 1'b0, 1, -1, -1);
        run_frame("ovr_mid", 32'd12345, 1'b0, 0, 35, -1);
        run_frame("after_lf", 32'd7, 1'b0, 0, -1, -1);
        run_frame("rst_mid", 32'hFFFF_FFFF, 1'b0, 0, -1, 3);
        run_frame("post_rst", 32'd42, 1'b0, 0, -1, -1);
        for (int k = 0; k < 8; k++) begin
            run_frame("rand", $urandom, 1'($urandom_range(0, 1)), k % 2, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
